// File: rtl/multiplier_pkg.sv
// ---------------------------------------------------------------------------
// multiplier_pkg
// Shared definitions for the sequential shift-and-add multiplier:
//   - MULT_WIDTH : default operand width
//   - mult_state_t : controller states (IDLE, CALC, FIN)
//   - cnt_width() : bit counter width for a given operand width
//   - MULT_CNT_W : counter width for the default operand width
// ---------------------------------------------------------------------------
package multiplier_pkg;

  localparam int MULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } mult_state_t;

  // The counter must reach WIDTH itself, hence WIDTH+1 distinct values.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int MULT_CNT_W = cnt_width(MULT_WIDTH);

endpackage

// File: rtl/multiplier_datapath.sv
// ---------------------------------------------------------------------------
// multiplier_datapath
// Shift-and-add datapath: multiplicand shift register (2*WIDTH, shifts left),
// multiplier shift register (WIDTH, shifts right), accumulator and adder.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   load       : capture a_in/b_in, clear the accumulator
//   step       : perform one iteration (conditional add, then shift)
//   a_in, b_in : unsigned operands (magnitudes)
//   acc        : current accumulator value
//   acc_next   : accumulator value after the iteration in progress
// ---------------------------------------------------------------------------
module multiplier_datapath
  import multiplier_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic [2*WIDTH-1:0]   acc,
  output logic [2*WIDTH-1:0]   acc_next
);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] addend;

  // NOTE: every variable written in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    addend   = '0;
    if (mplier[0]) addend = mcand;
    acc_next = acc + addend;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (load) begin
      mcand  <= {{WIDTH{1'b0}}, a_in};
      mplier <= b_in;
      acc    <= '0;
    end else if (step) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/multiplier_top.sv
// ---------------------------------------------------------------------------
// multiplier_top
// Sequential WIDTH x WIDTH shift-and-add multiplier. Captures A/B on valid
// (in IDLE), iterates one multiplier bit per clock, then loads prod and
// pulses DONE for one cycle. prod holds until the next result is loaded.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset (priority over valid)
//   valid : start strobe, sampled only in IDLE
//   A, B  : multiplicand, multiplier
//   prod  : registered 2*WIDTH-bit product
//   DONE  : registered one-cycle pulse when prod is updated
// Build option: define MULT_SIGNED_EN for two's complement operands
// (magnitudes are multiplied, the result is negated when signs differ).
// ---------------------------------------------------------------------------
module multiplier_top
  import multiplier_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   prod,
  output logic                 DONE
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mult_state_t        state;
  logic [CW-1:0]      cnt;
  logic               load, step;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] acc, acc_next, result;

  assign load = (state == IDLE) && valid;
  assign step = (state == CALC);

`ifdef MULT_SIGNED_EN
  logic neg_q;

  // The most negative value maps to itself under negation, and its
  // unsigned reading is exactly its magnitude, so no extra bit is needed.
  always_comb begin
    a_mag = A;
    b_mag = B;
    if (A[WIDTH-1]) a_mag = -A;
    if (B[WIDTH-1]) b_mag = -B;
  end

  always_ff @(posedge clk) begin
    if (rst)       neg_q <= 1'b0;
    else if (load) neg_q <= A[WIDTH-1] ^ B[WIDTH-1];
  end

  assign result = neg_q ? -acc_next : acc_next;
`else
  assign a_mag  = A;
  assign b_mag  = B;
  assign result = acc_next;
`endif

  multiplier_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .a_in     (a_mag),
    .b_in     (b_mag),
    .acc      (acc),
    .acc_next (acc_next)
  );

  // The edge performing the last iteration also loads prod from the
  // not-yet-registered accumulator sum, so DONE appears WIDTH cycles after
  // the capture edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      prod  <= '0;
      DONE  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (valid) begin
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            prod  <= result;
            DONE  <= 1'b1;
            state <= FIN;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier_top.sv
// ---------------------------------------------------------------------------
// tb_multiplier_top
// Directed and random stimulus for multiplier_top against an arithmetic
// reference product. Inputs are driven on the falling edge, outputs are
// sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_multiplier_top;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           valid;
  logic [W-1:0]   A, B;
  logic [2*W-1:0] prod;
  logic           DONE;

  int checks = 0;
  int errors = 0;

  multiplier_top #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .valid (valid),
    .A     (A),
    .B     (B),
    .prod  (prod),
    .DONE  (DONE)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MULT_SIGNED_EN
    int sa = $signed(a);
    int sb = $signed(b);
    return (2*W)'(sa * sb);
`else
    return (2*W)'(int'(a) * int'(b));
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One complete operation from IDLE: capture, latency, single pulse, hold.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit poke_valid);
    logic [2*W-1:0] exp, prev;
    int done_at, done_cnt;
    exp      = model(a, b);
    prev     = prod;
    done_at  = 99;
    done_cnt = 0;
    A = a; B = b; valid = 1'b1;
    @(posedge clk);                  // capture edge E0
    @(negedge clk);
    valid = 1'b0;
    A = W'($urandom); B = W'($urandom);
    for (int k = 1; k <= 10; k++) begin
      if (poke_valid && k == 2) begin
        valid = 1'b1;
        A = W'($urandom); B = W'($urandom);
      end
      tick();
      valid = 1'b0;
      if (k == 2) check({tag, "_hold_prev"}, 32'(prod), 32'(prev));
      if (DONE) begin
        done_cnt++;
        if (done_at == 99) begin
          done_at = k;
          check({tag, "_prod"}, 32'(prod), 32'(exp));
        end
      end
    end
    check({tag, "_latency"}, 32'(done_at), 32'd4);
    check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    check({tag, "_hold_after"}, 32'(prod), 32'(exp));
  endtask

  initial begin
    int dones[$];
    logic [W-1:0] ba, bb;
    int done_cnt;

    rst = 1'b1; valid = 1'b0; A = '0; B = '0;
    tick(); tick();
    check("reset_prod", 32'(prod), 32'd0);
    check("reset_done", 32'(DONE), 32'd0);
    rst = 1'b0;

    done_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (DONE) done_cnt++;
    end
    check("idle_no_done", 32'(done_cnt), 32'd0);
    check("idle_prod", 32'(prod), 32'd0);

    run_op("op_7x7", 4'd7, 4'd7, 1'b0);
    run_op("op_0x15", 4'd0, 4'd15, 1'b0);
    run_op("op_15x15", 4'd15, 4'd15, 1'b0);
    run_op("op_1x9", 4'd1, 4'd9, 1'b0);
    run_op("op_8x2", 4'd8, 4'd2, 1'b0);
    run_op("op_8x8", 4'd8, 4'd8, 1'b0);
    run_op("op_8x7", 4'd8, 4'd7, 1'b0);
    run_op("valid_in_calc", 4'd5, 4'd6, 1'b1);

    // Reset two cycles into an operation aborts it.
    A = 4'd11; B = 4'd13; valid = 1'b1;
    tick();                          // E0
    valid = 1'b0;
    tick(); tick();                  // E1, E2
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_prod", 32'(prod), 32'd0);
    check("abort_done", 32'(DONE), 32'd0);
    done_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (DONE) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    run_op("after_abort", 4'd11, 4'd13, 1'b0);

    for (int i = 0; i < 12; i++)
      run_op($sformatf("rand%0d", i), W'($urandom), W'($urandom), 1'b0);

    // valid held high: a new capture every WIDTH+2 cycles.
    ba = 4'd8; bb = 4'd7;            // unsigned 56, signed -56 (0xC8)
    A = ba; B = bb; valid = 1'b1;
    @(posedge clk);                  // E0
    @(negedge clk);
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (DONE) begin
        dones.push_back(k);
        check($sformatf("b2b_prod_at%0d", k), 32'(prod), 32'(model(ba, bb)));
      end
    end
    valid = 1'b0;
    check("b2b_count", 32'(dones.size()), 32'd3);
    if (dones.size() >= 3) begin
      check("b2b_first", 32'(dones[0]), 32'd4);
      check("b2b_gap1", 32'(dones[1] - dones[0]), 32'd6);
      check("b2b_gap2", 32'(dones[2] - dones[1]), 32'd6);
    end
`ifdef MULT_SIGNED_EN
    check("b2b_signed_c8", 32'(model(ba, bb)), 32'h000000C8);
`endif
    for (int k = 0; k < 8; k++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
